// File: rtl/theta_step_quantizer.sv
// theta_step_quantizer: converts two IEEE-754 double joint increments into
// signed 14-bit step counts, carrying a fixed-point sub-step residual per joint.
module theta_step_quantizer #(
    parameter int FRAC_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_ready,
    input  logic [63:0]        dth1,
    input  logic [63:0]        dth2,
    input  logic               clear_residual,
    output logic               busy,
    output logic               data_ready,
    output logic signed [13:0] step1,
    output logic signed [13:0] step2,
    output logic [1:0]         sat,
    output logic [1:0]         err
);
    localparam int W = 15 + FRAC_BITS;

    typedef enum logic [2:0] {IDLE, UNPACK1, ACCUM1, UNPACK2, ACCUM2, DONE} state_t;

    state_t                state, state_nx;
    logic [63:0]           cap1, cap2;
    logic signed [W-1:0]   fixed;
    logic signed [W-1:0]   res [2];
    logic signed [13:0]    st [2];
    logic [1:0]            sat_r, err_r;

    logic                  ch;
    logic [63:0]           d;
    logic [10:0]           ex;
    logic [51:0]           man;
    logic                  is_nan, is_sat, is_zero;
    logic [11:0]           shamt;
    logic [52:0]           mag;
    logic [W-1:0]          fx_mag;
    logic signed [W-1:0]   fx_un;
    logic signed [13:0]    sat_step;
    logic signed [W:0]     sum, rnd, diff;
    logic signed [15:0]    stp;
    logic                  ovf;
    logic signed [13:0]    acc_step;

    // channel 2 is handled in the second half of the sequence
    assign ch   = (state == UNPACK2) || (state == ACCUM2);
    assign busy = (state != IDLE);

    // next-state sequencing: a fixed six-state walk once a command is taken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_ready ? UNPACK1 : IDLE;
            UNPACK1: state_nx = ACCUM1;
            ACCUM1:  state_nx = UNPACK2;
            UNPACK2: state_nx = ACCUM2;
            ACCUM2:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // double to signed fixed point; with e <= 12 the mantissa only ever shifts right
    always_comb begin
        d        = ch ? cap2 : cap1;
        ex       = d[62:52];
        man      = d[51:0];
        is_nan   = (&ex) && (|man);
        is_sat   = !is_nan && (ex >= 11'd1036);
        is_zero  = ex < 11'(1022 - FRAC_BITS);
        shamt    = 12'(1075 - FRAC_BITS) - {1'b0, ex};
        mag      = {1'b1, man} >> shamt;
        fx_mag   = W'(mag);
        fx_un    = (is_nan || is_sat || is_zero) ? '0 :
                   (d[63] ? -$signed(fx_mag) : $signed(fx_mag));
        sat_step = d[63] ? -14'sd8192 : 14'sd8191;
    end

    // residual accumulation with round-half-up and clamping to the 14-bit range
    always_comb begin
        sum      = {fixed[W-1], fixed} + {res[ch][W-1], res[ch]};
        rnd      = sum + {{(W - FRAC_BITS + 1){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
        stp      = 16'(rnd >>> FRAC_BITS);
        diff     = sum - {stp, {FRAC_BITS{1'b0}}};
        ovf      = (stp[15:13] != 3'b000) && (stp[15:13] != 3'b111);
        acc_step = ovf ? (stp[15] ? -14'sd8192 : 14'sd8191) : stp[13:0];
    end

    // state, captured operands, per-channel results and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cap1       <= '0;
            cap2       <= '0;
            fixed      <= '0;
            res[0]     <= '0;
            res[1]     <= '0;
            st[0]      <= '0;
            st[1]      <= '0;
            sat_r      <= '0;
            err_r      <= '0;
            data_ready <= 1'b0;
            step1      <= '0;
            step2      <= '0;
            sat        <= '0;
            err        <= '0;
        end else begin
            state      <= state_nx;
            data_ready <= (state == DONE);
            case (state)
                IDLE: begin
                    if (clear_residual) begin
                        res[0] <= '0;
                        res[1] <= '0;
                    end
                    if (in_ready) begin
                        cap1  <= dth1;
                        cap2  <= dth2;
                        sat_r <= '0;
                        err_r <= '0;
                    end
                end
                UNPACK1, UNPACK2: begin
                    fixed <= fx_un;
                    if (is_nan) err_r[ch] <= 1'b1;
                    if (is_sat) begin
                        sat_r[ch] <= 1'b1;
                        st[ch]    <= sat_step;
                        res[ch]   <= '0;
                    end
                end
                ACCUM1, ACCUM2: begin
                    if (!sat_r[ch]) begin
                        st[ch]  <= acc_step;
                        res[ch] <= ovf ? '0 : W'(diff);
                        if (ovf) sat_r[ch] <= 1'b1;
                    end
                end
                DONE: begin
                    step1 <= st[0];
                    step2 <= st[1];
                    sat   <= sat_r;
                    err   <= err_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_theta_step_quantizer.sv
// tb_theta_step_quantizer: directed checks of conversion, residual carry, saturation, handshake and reset.
module tb_theta_step_quantizer;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_ready = 1'b0;
    logic               clear_residual = 1'b0;
    logic [63:0]        dth1 = '0;
    logic [63:0]        dth2 = '0;
    logic               busy, data_ready;
    logic signed [13:0] step1, step2;
    logic [1:0]         sat, err;
    int                 checks = 0;
    int                 failures = 0;

    localparam logic [63:0] NEG_INF = 64'hFFF0_0000_0000_0000;
    localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] DENORM  = 64'h0000_0000_0000_0001;

    always #5 clk = ~clk;

    theta_step_quantizer #(.FRAC_BITS(16)) dut (
        .clk(clk), .reset(reset), .in_ready(in_ready), .dth1(dth1), .dth2(dth2),
        .clear_residual(clear_residual), .busy(busy), .data_ready(data_ready),
        .step1(step1), .step2(step2), .sat(sat), .err(err)
    );

    function automatic logic [63:0] r(input real x);
        return $realtobits(x);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b, input logic clr,
                       input int e1, input int e2, input int es, input int ee);
        int n;
        @(negedge clk);
        dth1 = a; dth2 = b; in_ready = 1'b1; clear_residual = clr;
        @(posedge clk);
        #1 in_ready = 1'b0; clear_residual = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
            if (n == 1) chk({tag, ".busy"}, busy, 1);
        end while (!data_ready && n < 10);
        chk({tag, ".latency"}, n, 5);
        chk({tag, ".step1"}, step1, e1);
        chk({tag, ".step2"}, step2, e2);
        chk({tag, ".sat"}, sat, es);
        chk({tag, ".err"}, err, ee);
        @(posedge clk);
        #1 chk({tag, ".pulse"}, data_ready, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        logic [12:0] drm;
        int          seen;
        repeat (2) @(posedge clk);
        #1 chk("rst.step1", step1, 0);
        chk("rst.step2", step2, 0);
        chk("rst.sat", sat, 0);
        chk("rst.err", err, 0);
        chk("rst.dr", data_ready, 0);
        chk("rst.busy", busy, 0);
        @(negedge clk) reset = 1'b1;

        run("exact", r(1.0), r(-2.0), 0, 1, -2, 0, 0);
        run("carry1", r(0.3), r(0.0), 0, 0, 0, 0, 0);
        run("carry2", r(0.3), r(0.0), 0, 1, 0, 0, 0);
        run("carry3", r(0.3), r(0.0), 0, 0, 0, 0, 0);
        run("carry4", r(0.3), r(0.0), 0, 0, 0, 0, 0);
        @(negedge clk) clear_residual = 1'b1;
        @(negedge clk) clear_residual = 1'b0;
        run("after_clr", r(0.3), r(0.0), 0, 0, 0, 0, 0);
        run("clr_with_cmd", r(0.3), r(0.0), 1, 0, 0, 0, 0);
        run("half", r(0.5), r(-0.5), 1, 1, 0, 0, 0);
        run("round_2p4999", r(2.4999), r(0.0), 1, 2, 0, 0, 0);
        run("prime", r(0.3), r(0.3), 1, 0, 0, 0, 0);
        run("sat", r(1.0e6), NEG_INF, 0, 8191, -8192, 3, 0);
        run("post_sat", r(0.3), r(0.3), 0, 0, 0, 0, 0);
        run("special", DENORM, QNAN, 0, 0, 0, 0, 2);
        run("clamp", r(8191.75), r(-8191.5), 1, 8191, -8191, 1, 0);

        drm = '0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            in_ready = (c == 0 || c == 2 || c == 6);
            dth1 = (c == 0) ? r(1.0) : (c == 2) ? r(5.0) : r(3.0);
            dth2 = (c == 6) ? r(-3.0) : (c == 2) ? r(5.0) : r(0.0);
            @(posedge clk);
            #1 drm[c] = data_ready;
            if (c == 5) begin
                chk("hs.first.step1", step1, 1);
                chk("hs.first.step2", step2, 0);
            end
            if (c == 11) begin
                chk("hs.third.step1", step1, 3);
                chk("hs.third.step2", step2, -3);
            end
        end
        in_ready = 1'b0;
        chk("hs.dr_pattern", drm, 13'h820);

        @(negedge clk);
        dth1 = r(7.0); dth2 = r(-7.0); in_ready = 1'b1;
        @(posedge clk);
        #1 in_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("mid_rst.step1", step1, 0);
        chk("mid_rst.step2", step2, 0);
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.dr", data_ready, 0);
        @(negedge clk) reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (data_ready) seen++;
        end
        chk("mid_rst.no_dr", seen, 0);
        run("post_rst", r(1.0), r(0.0), 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
